// File: rtl/sdpb_fifo_if.sv
// Producer/consumer bus of the single-clock SDPB FIFO.
// master drives requests and write data; slave (the FIFO) returns data and status.
interface sdpb_fifo_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11
);
  logic              flush;
  logic              wr_en;
  logic [DATA_W-1:0] din;
  logic              rd_en;
  logic [DATA_W-1:0] dout;
  logic              dout_vld;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              ovf;
  logic              udf;

  modport master (
    output flush, wr_en, din, rd_en,
    input  dout, dout_vld, full, empty, almost_full, almost_empty, count, ovf, udf
  );

  modport slave (
    input  flush, wr_en, din, rd_en,
    output dout, dout_vld, full, empty, almost_full, almost_empty, count, ovf, udf
  );
endinterface

// File: rtl/sdpb_fifo.sv
// Single-clock FIFO on an inferred simple-dual-port RAM.
// Registered occupancy/flags, sticky overflow/underflow, synchronous flush,
// and a 1- or 2-cycle read data path selected by READ_MODE.
module sdpb_fifo #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 11,
  parameter int READ_MODE = 0,
  parameter int AFULL_TH  = 2040,
  parameter int AEMPTY_TH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  sdpb_fifo_if.slave     bus
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [ADDR_W:0]   DEPTH_C  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   AFULL_C  = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0]   AEMPTY_C = (ADDR_W+1)'(AEMPTY_TH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  if (DATA_W < 1 || DATA_W > 72) begin : g_bad_data_w
    $error("sdpb_fifo: DATA_W must be 1..72");
  end
  if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
    $error("sdpb_fifo: AFULL_TH must be 1..DEPTH");
  end
  if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
    $error("sdpb_fifo: AEMPTY_TH must be 0..DEPTH-1");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              afull_q, afull_d;
  logic              aempty_q, aempty_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              vld_p1_q;
  logic [DATA_W-1:0] ram_p1_q;
  logic [DATA_W-1:0] dout_q;
  logic              dout_vld_q;
  logic              wa, ra;

  // Accept/reject decisions and next occupancy; flush overrides everything.
  always_comb begin
    wa       = bus.wr_en & (~full_q | bus.rd_en) & ~bus.flush;
    ra       = bus.rd_en & ~empty_q & ~bus.flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (bus.wr_en & full_q & ~bus.rd_en);
    udf_d    = udf_q | (bus.rd_en & empty_q);
    if (wa) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (ra) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (wa & ~ra)      count_d = count_q + CNT_ONE;
    else if (ra & ~wa) count_d = count_q - CNT_ONE;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end
    full_d   = (count_d == DEPTH_C);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= AFULL_C);
    aempty_d = (count_d <= AEMPTY_C);
  end

  // Control state: pointers, occupancy, flags and first read-valid stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      vld_p1_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      vld_p1_q <= ra;
    end
  end

  // RAM write port; contents are never reset.
  always_ff @(posedge clk) begin
    if (wa) mem[wr_ptr_q] <= bus.din;
  end

  // RAM read port register (p1). Same-address read during a full write+read
  // returns the old word, which is the one being popped.
  always_ff @(posedge clk) begin
    if (ra) ram_p1_q <= mem[rd_ptr_q];
  end

  if (READ_MODE == 0) begin : g_bypass
    // Output register fed directly from the RAM read register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_q     <= '0;
        dout_vld_q <= 1'b0;
      end else begin
        dout_vld_q <= vld_p1_q & ~bus.flush;
        if (vld_p1_q & ~bus.flush) dout_q <= ram_p1_q;
      end
    end
  end else begin : g_pipelined
    logic              vld_p2_q;
    logic [DATA_W-1:0] ram_p2_q;

    // Extra pipeline stage (p2) between the RAM register and the output.
    always_ff @(posedge clk) begin
      if (vld_p1_q) ram_p2_q <= ram_p1_q;
    end

    // Output register and both valid stages; flush drops anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_p2_q   <= 1'b0;
        dout_q     <= '0;
        dout_vld_q <= 1'b0;
      end else begin
        vld_p2_q   <= vld_p1_q & ~bus.flush;
        dout_vld_q <= vld_p2_q & ~bus.flush;
        if (vld_p2_q & ~bus.flush) dout_q <= ram_p2_q;
      end
    end
  end

  assign bus.dout         = dout_q;
  assign bus.dout_vld     = dout_vld_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.count        = count_q;
  assign bus.ovf          = ovf_q;
  assign bus.udf          = udf_q;

endmodule

// File: tb/tb_sdpb_fifo.sv
// Bench for sdpb_fifo: two instances (bypass and pipelined read) driven by the
// same stimulus and compared every cycle against a queue-based FIFO model.
module tb_sdpb_fifo;
  localparam int DW    = 16;
  localparam int AW    = 11;
  localparam int DEPTH = 2048;
  localparam int AFT   = 2040;
  localparam int AET   = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic wr = 1'b0, rd = 1'b0, fl = 1'b0;
  logic [DW-1:0] din = '0;

  always #5 clk = ~clk;

  sdpb_fifo_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
  sdpb_fifo_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

  assign bus0.wr_en = wr;
  assign bus0.rd_en = rd;
  assign bus0.flush = fl;
  assign bus0.din   = din;
  assign bus1.wr_en = wr;
  assign bus1.rd_en = rd;
  assign bus1.flush = fl;
  assign bus1.din   = din;

  sdpb_fifo #(.DATA_W(DW), .ADDR_W(AW), .READ_MODE(0), .AFULL_TH(AFT), .AEMPTY_TH(AET))
    u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  sdpb_fifo #(.DATA_W(DW), .ADDR_W(AW), .READ_MODE(1), .AFULL_TH(AFT), .AEMPTY_TH(AET))
    u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // Model state: stored words, sticky flags, and words travelling to dout.
  logic [DW-1:0] mq[$];
  bit            m_ovf, m_udf;
  bit            p1_v, p2_v;
  logic [DW-1:0] p1_d, p2_d;
  bit            e_v0, e_v1;
  logic [DW-1:0] e_d0, e_d1;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task model_reset();
    mq.delete();
    m_ovf = 0; m_udf = 0;
    p1_v = 0; p2_v = 0;
    e_v0 = 0; e_v1 = 0;
    e_d0 = '0; e_d1 = '0;
  endtask

  task model_step();
    bit was_full, was_empty, ra, wa;
    if (!rst_n) return;
    if (fl) begin
      mq.delete();
      m_ovf = 0; m_udf = 0;
      p1_v = 0; p2_v = 0;
      e_v0 = 0; e_v1 = 0;
      return;
    end
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    ra = rd && !was_empty;
    wa = wr && (!was_full || rd);
    e_v0 = p1_v;
    if (p1_v) e_d0 = p1_d;
    e_v1 = p2_v;
    if (p2_v) e_d1 = p2_d;
    p2_v = p1_v;
    p2_d = p1_d;
    p1_v = ra;
    if (ra) p1_d = mq.pop_front();
    if (wa) mq.push_back(din);
    if (wr && was_full && !rd) m_ovf = 1;
    if (rd && was_empty) m_udf = 1;
  endtask

  task tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic cmp_dut(input string t, input logic [AW:0] cnt, input logic f, input logic e,
                         input logic af, input logic ae, input logic o, input logic u,
                         input logic v, input logic [DW-1:0] d, input bit ev, input logic [DW-1:0] ed);
    int sz;
    sz = mq.size();
    chk({t, "_count"}, 32'(cnt), 32'(sz));
    chk({t, "_full"},  32'(f),   32'(sz == DEPTH));
    chk({t, "_empty"}, 32'(e),   32'(sz == 0));
    chk({t, "_afull"}, 32'(af),  32'(sz >= AFT));
    chk({t, "_aempty"},32'(ae),  32'(sz <= AET));
    chk({t, "_ovf"},   32'(o),   32'(m_ovf));
    chk({t, "_udf"},   32'(u),   32'(m_udf));
    chk({t, "_vld"},   32'(v),   32'(ev));
    chk({t, "_dout"},  32'(d),   32'(ed));
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_dut("m0", bus0.count, bus0.full, bus0.empty, bus0.almost_full, bus0.almost_empty,
              bus0.ovf, bus0.udf, bus0.dout_vld, bus0.dout, e_v0, e_d0);
      cmp_dut("m1", bus1.count, bus1.full, bus1.empty, bus1.almost_full, bus1.almost_empty,
              bus1.ovf, bus1.udf, bus1.dout_vld, bus1.dout, e_v1, e_d1);
    end
  end

  task automatic chk_reset_state(input string t);
    chk({t, "_count0"}, 32'(bus0.count), 0);
    chk({t, "_empty0"}, 32'(bus0.empty), 1);
    chk({t, "_ae0"},    32'(bus0.almost_empty), 1);
    chk({t, "_full0"},  32'(bus0.full), 0);
    chk({t, "_dout0"},  32'(bus0.dout), 0);
    chk({t, "_vld0"},   32'(bus0.dout_vld), 0);
    chk({t, "_ovf0"},   32'(bus0.ovf), 0);
    chk({t, "_udf0"},   32'(bus0.udf), 0);
    chk({t, "_dout1"},  32'(bus1.dout), 0);
    chk({t, "_vld1"},   32'(bus1.dout_vld), 0);
  endtask

  initial begin
    int idx, first, last, npulse, pw, pr;
    #1 rst_n = 1'b0;
    model_reset();
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_reset_state("init");

    // Fill to full, watching almost_full cross at the 2040th write.
    wr = 1;
    for (int i = 0; i < DEPTH; i++) begin
      din = 16'(i);
      tick();
      if (i == AFT - 2) chk("afull_at_2039", 32'(bus0.almost_full), 0);
      if (i == AFT - 1) chk("afull_at_2040", 32'(bus0.almost_full), 1);
    end
    chk("fill_full", 32'(bus0.full), 1);
    chk("fill_count", 32'(bus0.count), 2048);
    din = 16'hBEEF;
    tick();
    wr = 0;
    chk("ovf_set", 32'(bus0.ovf), 1);
    chk("ovf_count", 32'(bus0.count), 2048);

    // Drain: the sequence must be 0..2047 with no 0xBEEF.
    idx = 0;
    for (int k = 0; k < DEPTH + 3; k++) begin
      rd = (k < DEPTH);
      tick();
      if (bus0.dout_vld) begin
        chk("drain_seq", 32'(bus0.dout), 32'(idx));
        idx++;
      end
    end
    rd = 0;
    chk("drain_words", 32'(idx), 2048);
    chk("drain_empty", 32'(bus0.empty), 1);

    // Wrap: four more words land at the start of the RAM and read back in order.
    wr = 1;
    for (int j = 0; j < 4; j++) begin
      din = 16'hA000 + 16'(j);
      tick();
    end
    wr = 0;
    idx = 0;
    for (int k = 0; k < 7; k++) begin
      rd = (k < 4);
      tick();
      if (bus0.dout_vld) begin
        chk("wrap_seq", 32'(bus0.dout), 32'h0000A000 + 32'(idx));
        idx++;
      end
    end
    rd = 0;
    chk("wrap_words", 32'(idx), 4);

    fl = 1; tick(); fl = 0;
    chk("flush_ovf", 32'(bus0.ovf), 0);

    // Full with simultaneous write and read: count pinned, no overflow.
    wr = 1;
    for (int i = 0; i < DEPTH; i++) begin
      din = 16'($urandom);
      tick();
    end
    rd = 1;
    for (int k = 0; k < 10; k++) begin
      din = 16'($urandom);
      tick();
      chk("simul_full_cnt", 32'(bus0.count), 2048);
      chk("simul_full_ovf", 32'(bus0.ovf), 0);
    end
    wr = 0; rd = 0;

    // Empty with simultaneous write and read: write wins, read flagged.
    fl = 1; tick(); fl = 0;
    wr = 1; rd = 1; din = 16'h0777;
    tick();
    wr = 0; rd = 0;
    chk("simul_empty_cnt", 32'(bus0.count), 1);
    chk("simul_empty_udf", 32'(bus0.udf), 1);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("simul_empty_novld0", 32'(bus0.dout_vld), 0);
      chk("simul_empty_novld1", 32'(bus1.dout_vld), 0);
    end

    // Latency of a single read in both modes.
    fl = 1; tick(); fl = 0;
    wr = 1; din = 16'h1234; tick(); wr = 0;
    tick();
    rd = 1; tick(); rd = 0;
    chk("lat_n_vld0", 32'(bus0.dout_vld), 0);
    tick();
    chk("lat_n1_vld0", 32'(bus0.dout_vld), 1);
    chk("lat_n1_dout0", 32'(bus0.dout), 32'h1234);
    chk("lat_n1_vld1", 32'(bus1.dout_vld), 0);
    tick();
    chk("lat_n2_vld1", 32'(bus1.dout_vld), 1);
    chk("lat_n2_dout1", 32'(bus1.dout), 32'h1234);
    chk("lat_n2_vld0", 32'(bus0.dout_vld), 0);

    // Back-to-back reads give a continuous valid run in pipelined mode.
    wr = 1;
    for (int j = 0; j < 5; j++) begin
      din = 16'h2000 + 16'(j);
      tick();
    end
    wr = 0;
    npulse = 0; first = -1; last = -1;
    for (int k = 0; k < 9; k++) begin
      rd = (k < 5);
      tick();
      if (bus1.dout_vld) begin
        if (first < 0) first = k;
        last = k;
        npulse++;
      end
    end
    rd = 0;
    chk("b2b_pulses", 32'(npulse), 5);
    chk("b2b_contig", 32'(last - first + 1), 5);

    // Flush with a read in flight and udf set.
    fl = 1; tick(); fl = 0;
    rd = 1; tick(); rd = 0;
    wr = 1;
    for (int j = 0; j < 100; j++) begin
      din = 16'h3000 + 16'(j);
      tick();
    end
    wr = 0;
    rd = 1; tick(); rd = 0;
    fl = 1; tick(); fl = 0;
    chk("fl_count", 32'(bus0.count), 0);
    chk("fl_empty", 32'(bus0.empty), 1);
    chk("fl_ovf", 32'(bus0.ovf), 0);
    chk("fl_udf", 32'(bus0.udf), 0);
    chk("fl_vld0", 32'(bus0.dout_vld), 0);
    chk("fl_vld1", 32'(bus1.dout_vld), 0);
    tick();
    chk("fl_late_vld0", 32'(bus0.dout_vld), 0);
    chk("fl_late_vld1", 32'(bus1.dout_vld), 0);
    wr = 1; din = 16'h5A5A; tick(); wr = 0;
    rd = 1; tick(); rd = 0;
    tick();
    chk("fl_next_dout0", 32'(bus0.dout), 32'h5A5A);
    tick();
    chk("fl_next_dout1", 32'(bus1.dout), 32'h5A5A);

    // Asynchronous reset mid-clock with reads in flight.
    wr = 1;
    for (int j = 0; j < 6; j++) begin
      din = 16'h4000 + 16'(j);
      tick();
    end
    wr = 0;
    rd = 1; tick(); tick(); rd = 0;
    #2 rst_n = 1'b0;
    #1 chk_reset_state("async");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("async_after_vld0", 32'(bus0.dout_vld), 0);
    chk("async_after_vld1", 32'(bus1.dout_vld), 0);

    // Randomized traffic in segments with different read/write bias.
    for (int seg = 0; seg < 8; seg++) begin
      pw = (seg % 2 == 0) ? 55 : 70;
      pr = (seg % 2 == 0) ? 60 : 40;
      for (int c = 0; c < 500; c++) begin
        wr  = ($urandom_range(0, 99) < pw);
        rd  = ($urandom_range(0, 99) < pr);
        fl  = ($urandom_range(0, 299) == 0);
        din = 16'($urandom);
        tick();
      end
    end
    wr = 0; rd = 0; fl = 0;
    repeat (4) tick();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sdpb_fifo.md
Name: sdpb_fifo

Overview:
- Parametrised single-clock synchronous FIFO built on an inferred simple-dual-port block RAM, one write port and one read port.
- Generalises the fixed 2048x16 SDPB wrapper to arbitrary width and depth, with selectable output pipelining.
- Adds pointer management, occupancy count, programmable almost-full/almost-empty flags, sticky error flags and flush.
- Used as the standard line/sample buffer between producer and consumer logic in the same clock domain.

Parameters:
- DATA_W, 16, data width in bits (1..72).
- ADDR_W, 11, address width; DEPTH = 2**ADDR_W entries (2048 by default).
- READ_MODE, 0, 0 = bypass (1-cycle read latency); 1 = pipelined (extra output register, 2-cycle latency).
- AFULL_TH, 2040, almost_full asserts when count >= AFULL_TH.
- AEMPTY_TH, 8, almost_empty asserts when count <= AEMPTY_TH.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of FIFO state.
- wr_en  in  1  write request.
- din  in  DATA_W  write data.
- rd_en  in  1  read request.
- dout  out  DATA_W  read data.
- dout_vld  out  1  one-cycle pulse marking new dout.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_TH.
- almost_empty  out  1  count <= AEMPTY_TH.
- count  out  ADDR_W+1  current occupancy.
- ovf  out  1  sticky overflow flag.
- udf  out  1  sticky underflow flag.

Behaviour:
- Reset (rst_n low, asynchronous): wr_ptr=0, rd_ptr=0, count=0, dout=0, dout_vld=0, empty=1, full=0, almost_empty=1, almost_full=0, ovf=0, udf=0. RAM contents are not reset.
- All flags and count are registered. Each updates at the same edge and reflects occupancy after that edge's operations.
- Write accepted (wa) = wr_en & (~full | rd_en). A write accepted at edge N stores din at wr_ptr. wr_ptr then increments modulo DEPTH, wrapping from DEPTH-1 to 0.
- Read accepted (ra) = rd_en & ~empty. An accepted read fetches the word at rd_ptr. rd_ptr then increments modulo DEPTH.
- count update: +1 if wa & ~ra; -1 if ra & ~wa; unchanged otherwise.
- Full with wr_en & rd_en: both operations are accepted and count stays at DEPTH.
- Empty with wr_en & rd_en: the write is accepted and the read is rejected. The result is count=1 and udf is set.
- Rejected write (wr_en & full & ~rd_en): RAM and pointers are unchanged; ovf is set to 1 and holds.
- Rejected read (rd_en & empty): pointers are unchanged; udf is set to 1 and holds.
- ovf and udf clear only on reset or flush.
- Read latency, READ_MODE=0: for a read accepted at edge N, dout is updated and dout_vld=1 after edge N+1.
- Read latency, READ_MODE=1: dout is updated and dout_vld=1 after edge N+2.
- dout holds its last value when no read completes. dout_vld is 0 on any cycle without a completing read.
- Write-to-read: a word written at edge N is readable by a read accepted at edge N+1 (empty deasserts after edge N). There is no same-cycle write-through.
- flush (synchronous): pointers, count, ovf, udf, dout_vld and the pipeline valid bits return to reset values. Any in-flight read is discarded (no dout_vld pulse). dout keeps its value. flush has priority over wr_en and rd_en in the same cycle.
- Reset asserted mid-operation aborts immediately, including in-flight reads.
- Thresholds: AFULL_TH must satisfy 1..DEPTH and AEMPTY_TH must satisfy 0..DEPTH-1. The design checks both at elaboration and fails on violation.

Test Plan:
- Reset: drive rst_n=0 asynchronously mid-clock -> immediately empty=1, almost_empty=1, count=0, dout=0, dout_vld=0, ovf=0, udf=0.
- Fill and overflow (defaults): write 0x0000..0x07FF on 2048 consecutive cycles.
  - Expect almost_full after the 2040th write; full=1 and count=2048 after the 2048th.
  - One extra write of 0xBEEF -> ovf=1, count stays 2048, contents unchanged.
- Drain and wrap: read all 2048 words -> dout sequence 0x0000..0x07FF with dout_vld each cycle, empty=1 at end.
  - Write 4 more words -> they are stored at addresses 0..3 after the wrap, and read back in order.
- Simultaneous operations:
  - At full, wr_en=rd_en=1 for 10 cycles -> count stays 2048, ovf stays 0.
  - At empty, wr_en=rd_en=1 -> count=1, udf=1, no dout_vld.
- Latency: with READ_MODE=0, rd_en at edge N -> dout_vld high after edge N+1. With READ_MODE=1 -> high after edge N+2, with back-to-back reads producing continuous dout_vld.
- Flush: with 100 words stored and a read in flight, pulse flush -> count=0, empty=1, ovf=udf=0, no dout_vld for the discarded read, and the next written word reads back first.
